// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - pipeline, debug and byte-RAM bus bundle for data_mem_ctrl
interface data_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    // pipeline (MEM stage) side
    logic                  i_pipe_req;
    logic                  i_pipe_write;
    logic [1:0]            i_pipe_size;
    logic                  i_pipe_unsigned;
    logic [ADDR_WIDTH-1:0] i_pipe_addr;
    logic [31:0]           i_pipe_wdata;
    logic                  o_pipe_stall;
    logic                  o_pipe_done;
    logic [31:0]           o_pipe_rdata;
    logic                  o_misaligned;
    // debug unit side
    logic                  i_dbg_req;
    logic [ADDR_WIDTH-1:0] i_dbg_addr;
    logic                  o_dbg_ack;
    logic [31:0]           o_dbg_rdata;
    // byte-wide RAM side
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [7:0]            o_ram_wdata;
    logic [7:0]            i_ram_rdata;

    // controller view
    modport slave (
        input  i_pipe_req, i_pipe_write, i_pipe_size, i_pipe_unsigned, i_pipe_addr, i_pipe_wdata,
        output o_pipe_stall, o_pipe_done, o_pipe_rdata, o_misaligned,
        input  i_dbg_req, i_dbg_addr,
        output o_dbg_ack, o_dbg_rdata,
        output o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata
    );

    // requester / RAM view
    modport master (
        output i_pipe_req, i_pipe_write, i_pipe_size, i_pipe_unsigned, i_pipe_addr, i_pipe_wdata,
        input  o_pipe_stall, o_pipe_done, o_pipe_rdata, o_misaligned,
        output i_dbg_req, i_dbg_addr,
        input  o_dbg_ack, o_dbg_rdata,
        input  o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-serial 32-bit load/store and debug word-read sequencer for a byte RAM
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic            i_clk,
    input  logic            i_reset,
    data_mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIPE = 2'd1,
        DBG  = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [1:0]            p_size;
    logic                  p_write;
    logic                  p_unsigned;
    logic [31:0]           p_wdata;
    logic [31:0]           asm_q;
    logic [31:0]           asm_next;
    logic [31:0]           load_ext;
    logic [1:0]            last_idx;
    logic                  req_mis;

    // misalignment of the request presented in IDLE (half on odd byte, word off a word boundary)
    always_comb begin
        req_mis = 1'b0;
        if (bus.i_pipe_size == 2'b01) begin
            req_mis = bus.i_pipe_addr[0];
        end else if (bus.i_pipe_size[1]) begin
            req_mis = (bus.i_pipe_addr[1:0] != 2'b00);
        end
    end

    // index of the final byte of the captured pipeline access
    always_comb begin
        case (p_size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // assembly word including the byte the RAM returns this cycle, so the final byte needs no extra cycle
    always_comb begin
        asm_next = asm_q;
        asm_next[{cnt, 3'b000} +: 8] = bus.i_ram_rdata;
    end

    // sign/zero extension of the assembled load data
    always_comb begin
        case (p_size)
            2'b00:   load_ext = p_unsigned ? {24'd0, asm_next[7:0]}
                                           : {{24{asm_next[7]}}, asm_next[7:0]};
            2'b01:   load_ext = p_unsigned ? {16'd0, asm_next[15:0]}
                                           : {{16{asm_next[15]}}, asm_next[15:0]};
            default: load_ext = asm_next;
        endcase
    end

    // RAM drive: quiet in IDLE, write strobe forced low whenever reset is asserted
    always_comb begin
        bus.o_ram_we    = 1'b0;
        bus.o_ram_addr  = '0;
        bus.o_ram_wdata = 8'd0;
        if (state == PIPE) begin
            bus.o_ram_addr = p_addr + ADDR_WIDTH'(cnt);
            if (p_write) begin
                bus.o_ram_we    = ~i_reset;
                bus.o_ram_wdata = p_wdata[{cnt, 3'b000} +: 8];
            end
        end else if (state == DBG) begin
            bus.o_ram_addr = d_addr + ADDR_WIDTH'(cnt);
        end
    end

    assign bus.o_pipe_stall = bus.i_pipe_req & ~bus.o_pipe_done;

    // arbitration and byte sequencing; done/ack/misaligned are one-cycle registered pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= IDLE;
            cnt              <= 2'd0;
            p_addr           <= '0;
            d_addr           <= '0;
            p_size           <= 2'd0;
            p_write          <= 1'b0;
            p_unsigned       <= 1'b0;
            p_wdata          <= 32'd0;
            asm_q            <= 32'd0;
            bus.o_pipe_done  <= 1'b0;
            bus.o_misaligned <= 1'b0;
            bus.o_pipe_rdata <= 32'd0;
            bus.o_dbg_ack    <= 1'b0;
            bus.o_dbg_rdata  <= 32'd0;
        end else begin
            bus.o_pipe_done  <= 1'b0;
            bus.o_misaligned <= 1'b0;
            bus.o_dbg_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    // a request still high during its own done/ack cycle is already consumed
                    if (bus.i_pipe_req && !bus.o_pipe_done) begin
                        p_addr     <= bus.i_pipe_addr;
                        p_size     <= bus.i_pipe_size;
                        p_write    <= bus.i_pipe_write;
                        p_unsigned <= bus.i_pipe_unsigned;
                        p_wdata    <= bus.i_pipe_wdata;
                        if (req_mis) begin
                            bus.o_pipe_done  <= 1'b1;
                            bus.o_misaligned <= 1'b1;
                            bus.o_pipe_rdata <= 32'd0;
                        end else begin
                            state <= PIPE;
                        end
                    end else if (bus.i_dbg_req && !bus.o_dbg_ack) begin
                        d_addr <= {bus.i_dbg_addr[ADDR_WIDTH-1:2], 2'b00};
                        state  <= DBG;
                    end
                end
                PIPE: begin
                    asm_q <= asm_next;
                    if (cnt == last_idx) begin
                        state           <= IDLE;
                        cnt             <= 2'd0;
                        bus.o_pipe_done <= 1'b1;
                        if (!p_write) begin
                            bus.o_pipe_rdata <= load_ext;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DBG: begin
                    asm_q <= asm_next;
                    if (cnt == 2'd3) begin
                        state           <= IDLE;
                        cnt             <= 2'd0;
                        bus.o_dbg_ack   <= 1'b1;
                        bus.o_dbg_rdata <= asm_next;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed vector bench for data_mem_ctrl with a byte RAM model
module tb_data_mem_ctrl;
    localparam int AW = 12;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   vecs = 0;
    int   errs = 0;
    logic [7:0] mem [0:4095];
    vec_t tbl [11];

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    assign bus.i_ram_rdata = mem[bus.o_ram_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
        end else if (bus.o_ram_we) begin
            mem[bus.o_ram_addr] <= bus.o_ram_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1
    task automatic do_pipe(input vec_t v, input string tag);
        int lat;
        bus.i_pipe_req      = 1'b1;
        bus.i_pipe_write    = v.wr;
        bus.i_pipe_size     = v.size;
        bus.i_pipe_unsigned = v.uns;
        bus.i_pipe_addr     = v.addr;
        bus.i_pipe_wdata    = v.wdata;
        lat = 0;
        @(negedge clk);
        chk({tag, " accept stall"}, 32'(bus.o_pipe_stall), 32'd1);
        chk({tag, " accept we"}, 32'(bus.o_ram_we), 32'd0);
        while (!bus.o_pipe_done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!bus.o_pipe_done) begin
                chk({tag, " busy stall"}, 32'(bus.o_pipe_stall), 32'd1);
                chk({tag, " ram addr"}, 32'(bus.o_ram_addr), 32'(12'(v.addr + 12'(lat - 1))));
                chk({tag, " ram we"}, 32'(bus.o_ram_we), 32'(v.wr));
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " rdata"}, bus.o_pipe_rdata, v.exp_rdata);
        chk({tag, " misaligned"}, 32'(bus.o_misaligned), 32'(v.exp_mis));
        chk({tag, " done stall"}, 32'(bus.o_pipe_stall), 32'd0);
        @(posedge clk);
        #1;
        bus.i_pipe_req = 1'b0;
        @(negedge clk);
        chk({tag, " no dup done"}, 32'(bus.o_pipe_done), 32'd0);
        chk({tag, " no dup addr"}, 32'(bus.o_ram_addr), 32'd0);
        chk({tag, " no dup we"}, 32'(bus.o_ram_we), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vec_t v;
        rst                 = 1'b1;
        mem_init            = 1'b1;
        bus.i_pipe_req      = 1'b0;
        bus.i_pipe_write    = 1'b0;
        bus.i_pipe_size     = 2'b00;
        bus.i_pipe_unsigned = 1'b0;
        bus.i_pipe_addr     = '0;
        bus.i_pipe_wdata    = 32'd0;
        bus.i_dbg_req       = 1'b0;
        bus.i_dbg_addr      = '0;

        //            wr    size   uns   addr     wdata         exp_rdata     mis   lat
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 5};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0, 5};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 12'h021, 32'h00000080, 32'hDEADBEEF, 1'b0, 2};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 12'h021, 32'h0,        32'hFFFFFF80, 1'b0, 2};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 12'h021, 32'h0,        32'h00000080, 1'b0, 2};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, 12'h020, 32'h0,        32'hFFFF8020, 1'b0, 3};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 12'h013, 32'h0,        32'h00000000, 1'b1, 1};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 12'h015, 32'h0000BEEF, 32'h00000000, 1'b1, 1};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 12'hFFF, 32'h0000005A, 32'h00000000, 1'b0, 2};
        tbl[9]  = '{1'b0, 2'b00, 1'b1, 12'hFFF, 32'h0,        32'h0000005A, 1'b0, 2};
        tbl[10] = '{1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        32'h0000DEAD, 1'b0, 3};

        @(posedge clk);
        #1;
        mem_init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset done", 32'(bus.o_pipe_done), 32'd0);
        chk("reset ack", 32'(bus.o_dbg_ack), 32'd0);
        chk("reset mis", 32'(bus.o_misaligned), 32'd0);
        chk("reset rdata", bus.o_pipe_rdata, 32'd0);
        chk("reset dbg rdata", bus.o_dbg_rdata, 32'd0);
        chk("reset we", 32'(bus.o_ram_we), 32'd0);
        chk("reset addr", 32'(bus.o_ram_addr), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            do_pipe(tbl[i], $sformatf("vec%0d", i));
        end
        chk("ram 010", 32'(mem[12'h010]), 32'hEF);
        chk("ram 011", 32'(mem[12'h011]), 32'hBE);
        chk("ram 012", 32'(mem[12'h012]), 32'hAD);
        chk("ram 013", 32'(mem[12'h013]), 32'hDE);
        chk("ram 015 untouched", 32'(mem[12'h015]), 32'h15);
        chk("ram 016 untouched", 32'(mem[12'h016]), 32'h16);
        chk("ram 021", 32'(mem[12'h021]), 32'h80);
        chk("ram FFF", 32'(mem[12'hFFF]), 32'h5A);

        // simultaneous pipeline and debug requests: pipeline first, debug right after its done
        bus.i_pipe_req      = 1'b1;
        bus.i_pipe_write    = 1'b0;
        bus.i_pipe_size     = 2'b00;
        bus.i_pipe_unsigned = 1'b1;
        bus.i_pipe_addr     = 12'h021;
        bus.i_dbg_req       = 1'b1;
        bus.i_dbg_addr      = 12'h012;
        n = 0;
        @(negedge clk);
        while (!bus.o_pipe_done && n < 20) begin
            @(negedge clk);
            n++;
            chk("arb no early ack", 32'(bus.o_dbg_ack), 32'd0);
        end
        chk("arb pipe latency", 32'(n), 32'd2);
        chk("arb pipe rdata", bus.o_pipe_rdata, 32'h00000080);
        @(posedge clk);
        #1;
        bus.i_pipe_req = 1'b0;
        @(negedge clk);
        chk("arb dbg first addr", 32'(bus.o_ram_addr), 32'h010);
        chk("arb dbg we", 32'(bus.o_ram_we), 32'd0);
        n = 0;
        while (!bus.o_dbg_ack && n < 20) begin
            @(negedge clk);
            n++;
            if (!bus.o_dbg_ack) chk("arb dbg we busy", 32'(bus.o_ram_we), 32'd0);
        end
        chk("arb dbg latency", 32'(n), 32'd4);
        chk("arb dbg rdata", bus.o_dbg_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        bus.i_dbg_req = 1'b0;
        @(negedge clk);
        chk("arb no dup ack", 32'(bus.o_dbg_ack), 32'd0);
        @(posedge clk);
        #1;

        // reset during the second byte of a word store
        bus.i_pipe_req   = 1'b1;
        bus.i_pipe_write = 1'b1;
        bus.i_pipe_size  = 2'b10;
        bus.i_pipe_addr  = 12'h040;
        bus.i_pipe_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst byte0 we", 32'(bus.o_ram_we), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst byte1 we", 32'(bus.o_ram_we), 32'd0);
        chk("rst no done", 32'(bus.o_pipe_done), 32'd0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.i_pipe_req = 1'b0;
        @(negedge clk);
        chk("post rst done", 32'(bus.o_pipe_done), 32'd0);
        chk("post rst ack", 32'(bus.o_dbg_ack), 32'd0);
        chk("post rst mis", 32'(bus.o_misaligned), 32'd0);
        chk("post rst rdata", bus.o_pipe_rdata, 32'd0);
        chk("post rst dbg rdata", bus.o_dbg_rdata, 32'd0);
        chk("post rst we", 32'(bus.o_ram_we), 32'd0);
        chk("post rst addr", 32'(bus.o_ram_addr), 32'd0);
        chk("post rst stall", 32'(bus.o_pipe_stall), 32'd0);
        chk("ram 040", 32'(mem[12'h040]), 32'h44);
        chk("ram 041", 32'(mem[12'h041]), 32'h41);
        chk("ram 042", 32'(mem[12'h042]), 32'h42);
        chk("ram 043", 32'(mem[12'h043]), 32'h43);
        @(posedge clk);
        #1;
        v = '{1'b0, 2'b00, 1'b1, 12'h040, 32'h0, 32'h00000044, 1'b0, 2};
        do_pipe(v, "after rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Sequences 32-bit pipeline loads/stores onto the byte-wide single-port data RAM, one byte per cycle, little-endian. Stalls the pipeline while a multi-byte access runs. Shares the same RAM with the debug unit, which issues word reads to dump memory. Sits between the MEM pipeline stage, the debug unit and the 4K x 8 data RAM (async read, sync write).

Parameters:
ADDR_WIDTH, 12, RAM byte-address width; all address arithmetic is modulo 2^ADDR_WIDTH.

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_pipe_req  in  1  pipeline access request; held high until o_pipe_done
i_pipe_write  in  1  1=store, 0=load
i_pipe_size  in  2  00 byte, 01 half, 10/11 word
i_pipe_unsigned  in  1  1=zero-extend loads, 0=sign-extend
i_pipe_addr  in  ADDR_WIDTH  byte address
i_pipe_wdata  in  32  store data, LSBs used for byte/half
o_pipe_stall  out  1  combinational: i_pipe_req & ~o_pipe_done
o_pipe_done  out  1  1-cycle pulse, access complete
o_pipe_rdata  out  32  load result, valid with o_pipe_done, held until next done
o_misaligned  out  1  pulse with o_pipe_done when access was misaligned
i_dbg_req  in  1  debug word-read request; held until o_dbg_ack
i_dbg_addr  in  ADDR_WIDTH  debug address; bits [1:0] ignored (forced 0)
o_dbg_ack  out  1  1-cycle pulse, o_dbg_rdata valid
o_dbg_rdata  out  32  debug word, held until next ack
o_ram_we  out  1  RAM write enable
o_ram_addr  out  ADDR_WIDTH  RAM byte address
o_ram_wdata  out  8  RAM write byte
i_ram_rdata  in  8  RAM async read byte

Behaviour:
- Reset: i_reset, synchronous, active-high; clock i_clk. On reset, the FSM goes to IDLE and the byte counter clears. o_pipe_done, o_dbg_ack, o_misaligned, o_pipe_rdata and o_dbg_rdata all go to 0. o_ram_we=0 in any cycle where i_reset=1.
- FSM states: IDLE, PIPE, DBG.
- IDLE arbitration: strict pipeline priority.
  - i_pipe_req=1 and o_pipe_done=0: capture addr, size, write, unsigned and wdata; go to PIPE.
  - Else if i_dbg_req=1 and o_dbg_ack=0: capture the debug address with [1:0]=0; go to DBG.
  - A request seen in the same cycle as its own done/ack pulse is treated as consumed and is not re-accepted.
- IDLE RAM outputs: o_ram_we=0, o_ram_addr=0, o_ram_wdata=0.
- Byte count N: byte=1, half=2, word=4.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No RAM cycle is issued; go from IDLE straight to the done pulse next cycle.
  - o_misaligned=1 and o_pipe_rdata=0 with that pulse.
- PIPE, cycle k (k=0..N-1): o_ram_addr = addr+k (wraps).
  - Store: o_ram_we=1 and o_ram_wdata = wdata[8k+7:8k].
  - Load: i_ram_rdata is latched into assembly byte k.
- PIPE exit: after byte N-1, go to IDLE. Next cycle: o_pipe_done=1 and o_pipe_rdata registered.
  - Loads: byte/half sign- or zero-extended per i_pipe_unsigned.
  - Stores: o_pipe_rdata keeps its previous value.
- Pipeline latency: accept cycle + N RAM cycles + done. Done arrives N+1 cycles after acceptance (misaligned: 1 cycle).
- DBG: 4 byte reads at addr+0..3, never writes. Next cycle: o_dbg_ack=1 and o_dbg_rdata = assembled word.
- Preemption: a debug access in progress is not preempted. A pipeline request arriving during DBG waits, stalled, until IDLE.
- Simultaneous requests in IDLE: pipeline wins; debug is served at the first IDLE cycle with no new pipeline request.
- Reset mid-access: the access is abandoned and no done/ack pulse is produced. Bytes already written remain in RAM.
- Wrap-around: addresses near 2^ADDR_WIDTH-1 wrap to 0 per byte. Only a byte access can reach this, since aligned accesses never wrap.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010. Required:
  - RAM bytes 0x10..0x13 = EF,BE,AD,DE.
  - o_pipe_rdata=0xDEADBEEF.
  - o_pipe_done exactly 5 cycles after accept for each access.
  - o_pipe_stall high until done.
- Byte 0x80 stored @0x021, then loads @0x021. Required:
  - Signed byte load gives 0xFFFFFF80.
  - Unsigned byte load gives 0x00000080.
  - Signed half load @0x020 gives 0xFFFF80xx, with the low byte taken from RAM 0x020.
- Word load @0x013 and half store @0x015. Required:
  - Each produces o_misaligned=1 with o_pipe_done 1 cycle after accept and o_pipe_rdata=0.
  - RAM is unchanged (o_ram_we never 1).
- i_pipe_req and i_dbg_req (addr 0x012) rise in the same cycle. Required:
  - Pipeline is served first.
  - Debug access starts the cycle after o_pipe_done.
  - o_dbg_rdata = word @0x010.
- Reset asserted during the 2nd byte of a word store 0x11223344 @0x040. Required:
  - Only RAM 0x040=0x44 is written.
  - No o_pipe_done.
  - All outputs are 0 after reset.
  - A subsequent request is accepted normally.
- Byte store 0x5A @0xFFF, then byte load @0xFFF. Required:
  - o_ram_addr=0xFFF.
  - Unsigned load returns 0x0000005A.
  - A back-to-back request held high across o_pipe_done is not duplicated.
